// File: rtl/seq_lock_if.sv
// Button-sequence lock bus: button code in, lock status out.
// The DUT binds the slave side; the driver binds the master side.
interface seq_lock_if #(
    parameter int NUM_BTN  = 3,
    parameter int SEQ_LEN  = 4,
    parameter int MAX_FAIL = 3
);
    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);

    logic [NUM_BTN:1] b;
    logic             outp;
    logic             alarm;
    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [FW-1:0]    fail_cnt;

    modport master (
        output b,
        input  outp, alarm, state, idx, fail_cnt
    );

    modport slave (
        input  b,
        output outp, alarm, state, idx, fail_cnt
    );
endinterface

// File: rtl/seq_lock_fsm.sv
// Programmable button-sequence lock with timeout, fail count and alarm.
// Define LOCK_AUTOCLEAR_EN to let ALARM clear itself after ALARM_CYCLES.
module seq_lock_fsm #(
    parameter int NUM_BTN      = 3,
    parameter int SEQ_LEN      = 4,
    parameter logic [NUM_BTN*SEQ_LEN-1:0] SEQ_CODE = 12'hD51,
    parameter int TIMEOUT      = 15,
    parameter int OPEN_CYCLES  = 8,
    parameter int MAX_FAIL     = 3,
    parameter int ALARM_CYCLES = 64
) (
    input  logic     clk,
    input  logic     rst,
    seq_lock_if.slave bus
);
    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int T0 = (TIMEOUT > OPEN_CYCLES) ? TIMEOUT : OPEN_CYCLES;
`ifdef LOCK_AUTOCLEAR_EN
    localparam int TMAX = (T0 > ALARM_CYCLES) ? T0 : ALARM_CYCLES;
`else
    localparam int TMAX = T0;
`endif
    localparam int TW = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        OPEN  = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t           state_q;
    logic [NUM_BTN:1] b_r_q;
    logic [NUM_BTN:1] b_prev_q;
    logic [IW-1:0]    idx_q;
    logic [FW-1:0]    fail_q;
    logic [TW-1:0]    tm_q;
    logic             outp_q;
    logic             alarm_q;

    logic [NUM_BTN-1:0] step [SEQ_LEN];
    logic               ev;
    logic [FW-1:0]      fail_d;
    logic               fail_hit;

    for (genvar g = 0; g < SEQ_LEN; g++) begin : g_step
        assign step[g] = SEQ_CODE[g*NUM_BTN +: NUM_BTN];
    end

    // A press is a nonzero code arriving straight after an all-released cycle.
    assign ev       = (b_prev_q == '0) && (b_r_q != '0);
    assign fail_hit = (fail_q >= FW'(MAX_FAIL - 1));
    assign fail_d   = fail_hit ? FW'(MAX_FAIL) : fail_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            b_r_q    <= '0;
            b_prev_q <= '0;
            idx_q    <= '0;
            fail_q   <= '0;
            tm_q     <= '0;
            outp_q   <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            b_r_q    <= bus.b;
            b_prev_q <= b_r_q;
            unique case (state_q)
                IDLE: begin
                    if (ev) begin
                        tm_q <= '0;
                        if (b_r_q == step[0]) begin
                            state_q <= ARMED;
                            idx_q   <= IW'(1);
                        end else begin
                            fail_q  <= fail_d;
                            state_q <= fail_hit ? ALARM : IDLE;
                            alarm_q <= fail_hit;
                            idx_q   <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (ev) begin
                        tm_q <= '0;
                        if (b_r_q == step[idx_q]) begin
                            if (idx_q == IW'(SEQ_LEN - 1)) begin
                                state_q <= OPEN;
                                outp_q  <= 1'b1;
                                idx_q   <= '0;
                                fail_q  <= '0;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end else begin
                            fail_q  <= fail_d;
                            state_q <= fail_hit ? ALARM : IDLE;
                            alarm_q <= fail_hit;
                            idx_q   <= '0;
                        end
                    end else if (tm_q == TW'(TIMEOUT - 1)) begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        tm_q    <= '0;
                    end else begin
                        tm_q <= tm_q + 1'b1;
                    end
                end
                OPEN: begin
                    if (tm_q == TW'(OPEN_CYCLES - 1)) begin
                        state_q <= IDLE;
                        outp_q  <= 1'b0;
                        tm_q    <= '0;
                    end else begin
                        tm_q <= tm_q + 1'b1;
                    end
                end
                ALARM: begin
`ifdef LOCK_AUTOCLEAR_EN
                    if (tm_q == TW'(ALARM_CYCLES - 1)) begin
                        state_q <= IDLE;
                        alarm_q <= 1'b0;
                        fail_q  <= '0;
                        idx_q   <= '0;
                        tm_q    <= '0;
                    end else begin
                        tm_q <= tm_q + 1'b1;
                    end
`else
                    alarm_q <= 1'b1;
`endif
                end
            endcase
        end
    end

    assign bus.outp     = outp_q;
    assign bus.alarm    = alarm_q;
    assign bus.state    = state_q;
    assign bus.idx      = idx_q;
    assign bus.fail_cnt = fail_q;
endmodule

// File: tb/tb_seq_lock_fsm.sv
// Directed bench for seq_lock_fsm with default parameters (code 1,2,5,6).
// Status is packed as {state, idx, fail_cnt, outp, alarm}.
module tb_seq_lock_fsm;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   hi;
    logic [7:0] obs;
    logic [7:0] exp;

    seq_lock_if #(.NUM_BTN(3), .SEQ_LEN(4), .MAX_FAIL(3)) bus ();

    seq_lock_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {bus.state, bus.idx, bus.fail_cnt, bus.outp, bus.alarm};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:1] c);
        bus.b = c;
        tick();
        tick();
    endtask

    task automatic rel();
        bus.b = '0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        bus.b = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.b = '0;
        rst = 1'b1;
        tick();
        exp = {2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset obs=%b exp=%b", obs, exp);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unlock();
        do_reset();
        press(3'd1);
        exp = {2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL unlock_s1 obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd2);
        exp = {2'd1, 2'd2, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL unlock_s2 obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd5);
        exp = {2'd1, 2'd3, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL unlock_s3 obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd6);
        exp = {2'd2, 2'd0, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL unlock_open obs=%b exp=%b", obs, exp);
        end
        bus.b = '0;
        hi = 0;
        repeat (7) begin
            tick();
            if (bus.outp === 1'b1) hi++;
        end
        checks++;
        if (hi !== 7) begin
            failures++;
            $display("FAIL unlock_open_len got=%0d want=7", hi);
        end
        tick();
        exp = {2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL unlock_close obs=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_wrong();
        do_reset();
        press(3'd1);
        rel();
        press(3'd3);
        exp = {2'd0, 2'd0, 2'd1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wrong_armed obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd2);
        exp = {2'd0, 2'd0, 2'd2, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL wrong_idle obs=%b exp=%b", obs, exp);
        end
        rel();
    endtask

    task automatic test_alarm();
        do_reset();
        press(3'd7);
        rel();
        press(3'd7);
        exp = {2'd0, 2'd0, 2'd2, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_pre obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd7);
        exp = {2'd3, 2'd0, 2'd3, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_enter obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd1);
        rel();
        press(3'd2);
        rel();
        press(3'd5);
        rel();
        press(3'd6);
        rel();
        exp = {2'd3, 2'd0, 2'd3, 1'b0, 1'b1};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_ignore obs=%b exp=%b", obs, exp);
        end
`ifdef LOCK_AUTOCLEAR_EN
        repeat (63 - 18) tick();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_hold obs=%b exp=%b", obs, exp);
        end
        tick();
        exp = {2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_clear obs=%b exp=%b", obs, exp);
        end
`else
        repeat (60) tick();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL alarm_sticky obs=%b exp=%b", obs, exp);
        end
`endif
    endtask

    task automatic test_hold_timeout();
        do_reset();
        bus.b = 3'd1;
        tick();
        tick();
        exp = {2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_event obs=%b exp=%b", obs, exp);
        end
        repeat (14) tick();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_pre_tmo obs=%b exp=%b", obs, exp);
        end
        tick();
        exp = {2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_tmo obs=%b exp=%b", obs, exp);
        end
        repeat (3) tick();
        bus.b = '0;
        tick();
        tick();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL hold_single obs=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_event_on_timeout();
        do_reset();
        press(3'd1);
        rel();
        repeat (11) tick();
        bus.b = 3'd1;
        tick();
        exp = {2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL tmo_race_pre obs=%b exp=%b", obs, exp);
        end
        tick();
        exp = {2'd0, 2'd0, 2'd1, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL tmo_race obs=%b exp=%b", obs, exp);
        end
        rel();
    endtask

    task automatic test_back_to_back();
        do_reset();
        press(3'd1);
        bus.b = 3'd2;
        tick();
        tick();
        tick();
        exp = {2'd1, 2'd1, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL no_release obs=%b exp=%b", obs, exp);
        end
        rel();
        press(3'd2);
        exp = {2'd1, 2'd2, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL after_release obs=%b exp=%b", obs, exp);
        end
        rel();
    endtask

    task automatic test_rst_mid_open();
        do_reset();
        press(3'd1);
        rel();
        press(3'd2);
        rel();
        press(3'd5);
        rel();
        press(3'd6);
        bus.b = '0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        exp = {2'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rst_async obs=%b exp=%b", obs, exp);
        end
        tick();
        rst = 1'b0;
        tick();
        press(3'd1);
        rel();
        press(3'd2);
        rel();
        press(3'd5);
        rel();
        press(3'd6);
        exp = {2'd2, 2'd0, 2'd0, 1'b1, 1'b0};
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL rst_reunlock obs=%b exp=%b", obs, exp);
        end
        rel();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.b    = '0;
        test_reset();
        test_unlock();
        test_wrong();
        test_alarm();
        test_hold_timeout();
        test_event_on_timeout();
        test_back_to_back();
        test_rst_mid_open();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_lock_fsm.md
Name: seq_lock_fsm

Overview:
Parametrised successor to the team's fixed 3-button state machine: a button-sequence lock FSM. It detects a programmable sequence of SEQ_LEN button codes on an NUM_BTN-wide input, with inactivity timeout, failed-attempt counting and alarm lockout. Its outputs drive the unlock indicator (outp) and alarm in the board-level demo.

Parameters:
NUM_BTN, 3, width of button input b
SEQ_LEN, 4, number of codes in the unlock sequence (2..16)
SEQ_CODE, 12'hD51, packed sequence, step 0 in LSBs, NUM_BTN bits per step; default = 1,2,5,6; all-zero step not allowed
TIMEOUT, 15, idle cycles in ARMED before abandoning the attempt (>=2)
OPEN_CYCLES, 8, cycles outp stays high after a correct sequence (>=1)
MAX_FAIL, 3, wrong-code events before ALARM (>=1)
ALARM_CYCLES, 64, ALARM auto-clear length (only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
b  in  [NUM_BTN:1]  button code, synchronous to clk
outp  out  1  unlocked indicator, high in OPEN
alarm  out  1  high in ALARM
state  out  2  current state: 0 IDLE, 1 ARMED, 2 OPEN, 3 ALARM
idx  out  clog2(SEQ_LEN)  next sequence step expected
fail_cnt  out  clog2(MAX_FAIL+1)  wrong-code events since last success/reset

Behaviour:
- Reset (async, active-high): state=IDLE, idx=0, fail_cnt=0, outp=0, alarm=0, b_r=0, b_prev=0, timers=0; outputs drop immediately on rst assert.
- Input stage: b_r <= b each edge; b_prev <= b_r. Press event (comb) = (b_prev==0) && (b_r!=0), code = b_r. Holding a code gives exactly one event; a code change without passing through 0 is not an event.
- Latency: b applied before edge k → b_r at edge k → state/outputs update at edge k+1.
- IDLE: event with code==step0 → ARMED, idx=1. Event with wrong code → fail_cnt+1, stay IDLE.
- ARMED: timeout counter clears on any event and increments otherwise; at TIMEOUT → IDLE, idx=0, fail_cnt unchanged. Event with code==step[idx]: if idx==SEQ_LEN-1 → OPEN, idx=0, fail_cnt=0; else idx+1. Wrong code → IDLE, idx=0, fail_cnt+1 (no overlap restart).
- Failure limit: when an increment makes fail_cnt==MAX_FAIL → ALARM in the same transition; fail_cnt saturates at MAX_FAIL.
- OPEN: outp=1 for exactly OPEN_CYCLES cycles, then IDLE. Events are ignored.
- ALARM: alarm=1; all events ignored; exit only by rst (see optional feature).
- Simultaneous event and timeout expiry in ARMED: the event wins.
- outp, alarm and state are registered (no comb path from b).

Optional Feature:
LOCK_AUTOCLEAR_EN: when defined, ALARM counts ALARM_CYCLES cycles, then enters IDLE with fail_cnt=0 and idx=0. When undefined, ALARM is sticky until rst and no ALARM counter is built.

Test Plan:
- rst pulse, then b=1,2,5,6 (each held 2 cycles, 0 for 2 cycles between) → idx 1,2,3, then state=2 and outp=1 from the 2nd edge after b=6, for 8 cycles, then state=0; fail_cnt=0.
- b=1 then b=3 → idx=1 then state=0, idx=0, fail_cnt=1; next b=2 alone → fail_cnt=2.
- Three wrong codes (b=7, 7, 7 with releases) → fail_cnt=3, alarm=1, state=3; correct 1,2,5,6 then ignored (outp=0). With LOCK_AUTOCLEAR_EN: alarm=0, state=0 after 64 cycles.
- b=1 held 20 cycles, then 0 → one event only: idx=1; after 15 idle cycles in ARMED → state=0, idx=0, fail_cnt unchanged.
- b=1 pressed so its event lands on the timeout-expiry cycle during ARMED at idx=1 → treated as a wrong code: state=0, fail_cnt+1 (the event wins over the timeout).
- rst asserted mid-OPEN (cycle 3) → outp=0 asynchronously, state=0, fail_cnt=0; after release, full sequence unlocks normally.
